// File: rtl/key_loader_pkg.sv
// Shared types, default sizes and the effective-length helper used by key_loader.
package key_loader_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_KEY_W  = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_e;

    // A requested length of 0 means "whole key"; anything longer saturates at the key depth.
    function automatic int eff_len(input int len, input int depth);
        if (len == 0 || len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage : key_loader_pkg

// File: rtl/key_loader_tiler.sv
// key_tiler: combinational replication of the first L stored slots across the whole key.
module key_tiler #(
    parameter int WORD_W = 32,
    parameter int KEY_W  = 512,
    parameter int CNT_W  = 5
) (
    input  logic [KEY_W-1:0] iRaw_key,
    input  logic [CNT_W-1:0] iLen,
    input  logic             iFull,
    output logic [KEY_W-1:0] oKey
);

    localparam int DEPTH = KEY_W / WORD_W;

    logic [KEY_W-1:0] tiled;

    // A wrapping source index replaces k mod L, avoiding a variable-divisor modulo.
    always_comb begin
        int src;
        tiled = '0;
        src   = 0;
        for (int k = 0; k < DEPTH; k++) begin
            tiled[k*WORD_W +: WORD_W] = iRaw_key[src*WORD_W +: WORD_W];
            src = (src + 1 >= int'(iLen)) ? 0 : src + 1;
        end
    end

    assign oKey = iFull ? tiled : iRaw_key;

endmodule : key_tiler

// File: rtl/key_loader.sv
// key_loader: assembles a streamed key LSB-first and tiles short keys across KEY_W.
// Optional running XOR of accepted words on oKey_sum when KEY_LOADER_CHECKSUM_EN is defined.
module key_loader
    import key_loader_pkg::*;
#(
    parameter  int WORD_W = DEF_WORD_W,
    parameter  int KEY_W  = DEF_KEY_W,
    localparam int DEPTH  = KEY_W / WORD_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    input  logic [CNT_W-1:0]  iLen,
    input  logic              iWord_valid,
    input  logic [WORD_W-1:0] iWord,
    output logic              oWord_ready,
    output logic [KEY_W-1:0]  oKey,
    output logic              oKey_valid,
    output logic [CNT_W-1:0]  oWord_count,
`ifdef KEY_LOADER_CHECKSUM_EN
    output logic              oDropped,
    output logic [WORD_W-1:0] oKey_sum
`else
    output logic              oDropped
`endif
);

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [CNT_W-1:0]  len_q,     len_d;
    logic [KEY_W-1:0]  key_q,     key_d;
    logic              dropped_q, dropped_d;

    logic              word_ready;
    logic              accept;
    logic [CNT_W-1:0]  load_len;
    logic [CNT_W-1:0]  count_inc;

    // Ready depends only on the registered state, never on iWord_valid.
    assign word_ready = (state_q != FULL);
    assign accept     = iWord_valid && word_ready && !iClear;
    assign count_inc  = count_q + CNT_W'(1);
    assign load_len   = (state_q == IDLE) ? CNT_W'(eff_len(int'(iLen), DEPTH)) : len_q;

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        key_d     = key_q;
        dropped_d = dropped_q;

        if (iClear) begin
            state_d   = IDLE;
            count_d   = '0;
            len_d     = '0;
            key_d     = '0;
            dropped_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        for (int s = 0; s < DEPTH; s++) begin
                            if (count_q == CNT_W'(s)) begin
                                key_d[s*WORD_W +: WORD_W] = iWord;
                            end
                        end
                        len_d   = load_len;
                        count_d = count_inc;
                        state_d = (count_inc == load_len) ? FULL : LOAD;
                    end
                end
                FULL: begin
                    if (iWord_valid) begin
                        dropped_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: the key register is reset, not left uninitialised like a RAM: partial keys must vanish on reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            len_q     <= '0;
            key_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            key_q     <= key_d;
            dropped_q <= dropped_d;
        end
    end

`ifdef KEY_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (iClear) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q ^ iWord;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign oKey_sum = sum_q;
`endif

    key_tiler #(
        .WORD_W (WORD_W),
        .KEY_W  (KEY_W),
        .CNT_W  (CNT_W)
    ) u_tiler (
        .iRaw_key (key_q),
        .iLen     (len_q),
        .iFull    (state_q == FULL),
        .oKey     (oKey)
    );

    assign oWord_ready = word_ready;
    assign oKey_valid  = (state_q == FULL);
    assign oWord_count = count_q;
    assign oDropped    = dropped_q;

endmodule : key_loader

// File: tb/tb_key_loader.sv
// Directed bench for key_loader at default sizes; define KEY_LOADER_CHECKSUM_EN to cover oKey_sum.
module tb_key_loader;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 512;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iClear;
    logic [CNT_W-1:0]  iLen;
    logic              iWord_valid;
    logic [WORD_W-1:0] iWord;
    logic              oWord_ready;
    logic [KEY_W-1:0]  oKey;
    logic              oKey_valid;
    logic [CNT_W-1:0]  oWord_count;
    logic              oDropped;
`ifdef KEY_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] oKey_sum;
`endif

    int checks = 0;
    int errors = 0;

    logic [KEY_W-1:0]  exp_key;
    logic [WORD_W-1:0] words [DEPTH];

    key_loader dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iClear      (iClear),
        .iLen        (iLen),
        .iWord_valid (iWord_valid),
        .iWord       (iWord),
        .oWord_ready (oWord_ready),
        .oKey        (oKey),
        .oKey_valid  (oKey_valid),
        .oWord_count (oWord_count),
`ifdef KEY_LOADER_CHECKSUM_EN
        .oDropped    (oDropped),
        .oKey_sum    (oKey_sum)
`else
        .oDropped    (oDropped)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too, half a cycle after the active edge.
    task automatic cycle();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic put(input logic [WORD_W-1:0] w);
        iWord_valid = 1'b1;
        iWord       = w;
        cycle();
    endtask

    task automatic idle();
        iWord_valid = 1'b0;
        iWord       = '0;
    endtask

    task automatic clear_pulse();
        iClear = 1'b1;
        cycle();
        iClear = 1'b0;
    endtask

    task automatic build_exp(input int len);
        exp_key = '0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_key[k*WORD_W +: WORD_W] = words[k % len];
        end
    endtask

    initial begin
        iRst        = 1'b0;
        iClear      = 1'b0;
        iLen        = '0;
        iWord_valid = 1'b0;
        iWord       = '0;
        repeat (3) @(negedge iClk);

        check("rst_ready", KEY_W'(oWord_ready), KEY_W'(1));
        check("rst_valid", KEY_W'(oKey_valid), KEY_W'(0));
        check("rst_key", oKey, '0);
        check("rst_count", KEY_W'(oWord_count), KEY_W'(0));
        check("rst_dropped", KEY_W'(oDropped), KEY_W'(0));
        iRst = 1'b1;
        cycle();

        // Full 16-word load, length 0 meaning whole key.
        iLen = 5'd0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = WORD_W'(i + 1);
            put(words[i]);
            if (i == DEPTH - 2) begin
                check("full_valid_before_last", KEY_W'(oKey_valid), KEY_W'(0));
                check("full_ready_before_last", KEY_W'(oWord_ready), KEY_W'(1));
            end
        end
        idle();
        build_exp(DEPTH);
        check("full_valid", KEY_W'(oKey_valid), KEY_W'(1));
        check("full_count", KEY_W'(oWord_count), KEY_W'(16));
        check("full_slot0", KEY_W'(oKey[31:0]), KEY_W'(32'h1));
        check("full_slot15", KEY_W'(oKey[511:480]), KEY_W'(32'h10));
        check("full_key", oKey, exp_key);
        check("full_ready", KEY_W'(oWord_ready), KEY_W'(0));

        // Words presented while full are dropped and flagged.
        put(32'hDEAD_BEEF);
        put(32'hCAFE_F00D);
        idle();
        check("drop_key", oKey, exp_key);
        check("drop_count", KEY_W'(oWord_count), KEY_W'(16));
        check("drop_flag", KEY_W'(oDropped), KEY_W'(1));
        clear_pulse();
        check("clr_dropped", KEY_W'(oDropped), KEY_W'(0));
        check("clr_ready", KEY_W'(oWord_ready), KEY_W'(1));
        check("clr_key", oKey, '0);
        check("clr_valid", KEY_W'(oKey_valid), KEY_W'(0));
        check("clr_count", KEY_W'(oWord_count), KEY_W'(0));

        // Short key of 3 words tiles A,B,C,A,...
        iLen = 5'd3;
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        put(words[0]);
        put(words[1]);
        check("short_raw_partial", oKey, {448'd0, words[1], words[0]});
        check("short_valid_partial", KEY_W'(oKey_valid), KEY_W'(0));
        put(words[2]);
        idle();
        build_exp(3);
        check("short_valid", KEY_W'(oKey_valid), KEY_W'(1));
        check("short_slot15", KEY_W'(oKey[511:480]), KEY_W'(32'hAAAA_0001));
        check("short_key", oKey, exp_key);
        clear_pulse();

        // Length 1 fills straight from IDLE and replicates one word everywhere.
        iLen = 5'd1;
        words[0] = 32'h1234_5678;
        put(words[0]);
        idle();
        build_exp(1);
        check("len1_valid", KEY_W'(oKey_valid), KEY_W'(1));
        check("len1_key", oKey, exp_key);
        clear_pulse();

        // Oversized length clamps to 16 words.
        iLen = 5'd20;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = 32'h5000_0000 + WORD_W'(i);
            put(words[i]);
            if (i == DEPTH - 2) begin
                check("clamp_valid_at_15", KEY_W'(oKey_valid), KEY_W'(0));
            end
        end
        idle();
        build_exp(DEPTH);
        check("clamp_valid_at_16", KEY_W'(oKey_valid), KEY_W'(1));
        check("clamp_count", KEY_W'(oWord_count), KEY_W'(16));
        check("clamp_key", oKey, exp_key);
        clear_pulse();

        // Clear colliding with a valid word at count 5.
        iLen = 5'd0;
        for (int i = 0; i < 5; i++) begin
            put(WORD_W'(32'h7700 + i));
        end
        check("coll_count_before", KEY_W'(oWord_count), KEY_W'(5));
        iClear = 1'b1;
        put(32'h5555_5555);
        iClear = 1'b0;
        idle();
        check("coll_count", KEY_W'(oWord_count), KEY_W'(0));
        check("coll_ready", KEY_W'(oWord_ready), KEY_W'(1));
        check("coll_key", oKey, '0);
        check("coll_dropped", KEY_W'(oDropped), KEY_W'(0));
        check("coll_valid", KEY_W'(oKey_valid), KEY_W'(0));

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 7; i++) begin
            put(WORD_W'(32'h9900 + i));
        end
        idle();
        check("mid_count_before", KEY_W'(oWord_count), KEY_W'(7));
        #1 iRst = 1'b0;
        #1;
        check("arst_count", KEY_W'(oWord_count), KEY_W'(0));
        check("arst_key", oKey, '0);
        check("arst_ready", KEY_W'(oWord_ready), KEY_W'(1));
        check("arst_valid", KEY_W'(oKey_valid), KEY_W'(0));
        check("arst_dropped", KEY_W'(oDropped), KEY_W'(0));
`ifdef KEY_LOADER_CHECKSUM_EN
        check("arst_sum", KEY_W'(oKey_sum), KEY_W'(0));
`endif
        @(negedge iClk);
        iRst = 1'b1;
        cycle();

        put(32'hF0F0_F0F0);
        put(32'h0F0F_0F0F);
        idle();
        check("post_count", KEY_W'(oWord_count), KEY_W'(2));
        check("post_key", oKey, {448'd0, 32'h0F0F_0F0F, 32'hF0F0_F0F0});
`ifdef KEY_LOADER_CHECKSUM_EN
        check("post_sum", KEY_W'(oKey_sum), KEY_W'(32'hFFFF_FFFF));
        clear_pulse();
        check("clr_sum", KEY_W'(oKey_sum), KEY_W'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_loader
